// File: rtl/inst_prefetch_pkg.sv
// rtl/inst_prefetch_pkg.sv - shared FSM encodings and queue depth default for the prefetcher
package inst_prefetch_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH x 32 prefetch data queue with flush and head-of-queue output
module prefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [31:0]             push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full queue is still legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetcher: fetch FSM, address tracking and core-side match
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_d;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_addr_d;
  logic [31:0]   exp_pc;
  logic [31:0]   imem_addr_d;
  logic          imem_req_d;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;
  logic [31:0]   head;
  logic          redirect;
  logic          pop;
  logic          push;
  logic          ack_fire;

  assign redirect    = pc[31:2] != exp_pc[31:2];
  assign inst_valid  = (count != '0) && !redirect;
  assign inst        = inst_valid ? head : '0;
  assign pop         = inst_valid && inst_ready;
  assign ack_fire    = imem_req && imem_ack;
  assign push        = (state == BUSY) && ack_fire && !redirect;
  assign count_after = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (reset),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    state_d      = state;
    fetch_addr_d = fetch_addr;
    imem_req_d   = imem_req;
    imem_addr_d  = imem_addr;
    if (redirect) fetch_addr_d = {pc[31:2], 2'b00};
    case (state)
      IDLE: begin
        if (!redirect && (count < CW'(DEPTH))) begin
          state_d     = BUSY;
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_addr;
        end
      end
      BUSY: begin
        if (ack_fire) begin
          if (redirect) begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
          end else begin
            fetch_addr_d = fetch_addr + 32'd4;
            if (count_after < (CW + 1)'(DEPTH)) begin
              imem_addr_d = fetch_addr + 32'd4;
            end else begin
              state_d    = IDLE;
              imem_req_d = 1'b0;
            end
          end
        end else if (redirect) begin
          // Keep the request on the bus until memory answers; its data is dropped.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ack_fire) begin
          state_d    = IDLE;
          imem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_addr <= '0;
      exp_pc     <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
    end else begin
      state      <= state_d;
      fetch_addr <= fetch_addr_d;
      imem_req   <= imem_req_d;
      imem_addr  <= imem_addr_d;
      if (redirect) exp_pc <= {pc[31:2], 2'b00};
      else if (pop) exp_pc <= exp_pc + 32'd4;
    end
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4 (power of 2, >=2), meaning the number of prefetch queue entries.
REQ-002 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  meaning reset, synchronous and active-low.
REQ-004 The block SHALL have port pc  input  32  meaning the core's current fetch address; bits [1:0] ignored.
REQ-005 The block SHALL have port inst  output  32  meaning the instruction word for pc; 0 when inst_valid=0.
REQ-006 The block SHALL have port inst_valid  output  1  meaning inst holds the word at pc; core stalls while low.
REQ-007 The block SHALL have port inst_ready  input  1  meaning the core consumes inst this cycle.
REQ-008 The block SHALL have port imem_req  output  1  meaning a registered instruction-memory read request.
REQ-009 The block SHALL have port imem_addr  output  32  meaning a word-aligned request address, with bits [1:0]=0.
REQ-010 The block SHALL have port imem_ack  input  1  meaning the request completes this cycle and imem_rdata is valid.
REQ-011 The block SHALL have port imem_rdata  input  32  meaning read data, sampled only when imem_req and imem_ack are both high.

Function
REQ-012 The queue SHALL store data words only; entry addresses are implied by exp_pc, the head address, plus 4 per entry.
REQ-013 Head match means count>0 and pc[31:2]==exp_pc[31:2]; when head match holds, inst_valid SHALL be 1 and inst SHALL be the head data, combinationally.
REQ-014 On inst_valid and inst_ready, the head SHALL be popped and exp_pc SHALL be incremented by 4.
REQ-015 A redirect is pc[31:2]!=exp_pc[31:2]; while a redirect is present, inst_valid SHALL be 0, pop SHALL be suppressed, and no data SHALL be pushed.
REQ-016 On a redirect, at the next edge count SHALL be set to 0 and fetch_addr and exp_pc SHALL be set to {pc[31:2],2'b00}.
REQ-017 The FSM SHALL have states IDLE, BUSY and DRAIN, where DRAIN means a request is in flight and its data is to be discarded.
REQ-018 In IDLE, if count<DEPTH and there is no redirect, the FSM SHALL go to BUSY, setting imem_req=1 and imem_addr=fetch_addr.
REQ-019 In BUSY, imem_req and imem_addr SHALL stay stable until imem_ack, and a redirect without ack SHALL cause a transition to DRAIN.
REQ-020 In BUSY on ack without redirect, the block SHALL push imem_rdata and add 4 to fetch_addr; it SHALL stay in BUSY with the next address if post-update count<DEPTH, else go to IDLE with imem_req=0.
REQ-021 In BUSY on ack together with a redirect, the data SHALL be discarded, fetch_addr SHALL be set to pc, and the FSM SHALL go to IDLE.
REQ-022 In DRAIN on ack, the data SHALL be discarded and the FSM SHALL go to IDLE; a further redirect in DRAIN SHALL only update fetch_addr and exp_pc.
REQ-023 At most one request SHALL be outstanding; with a zero-wait memory (ack in the same cycle as req), sustained throughput SHALL be one word per cycle.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged, and count SHALL never exceed DEPTH or underflow.
REQ-025 Addresses SHALL wrap modulo 2^32, so 0xFFFFFFFC+4 gives 0x00000000.
REQ-026 Queue pointers SHALL wrap modulo DEPTH.
REQ-027 Latency SHALL be: ack edge -> inst_valid in the next cycle, provided pc matches.

Reset
REQ-028 On a rising clk edge with reset=0, the block SHALL clear count, the pointers, fetch_addr, exp_pc and the state to IDLE, set imem_req=0 and imem_addr=0, and thereby force inst_valid=0 and inst=0.
REQ-029 A reset issued mid-request SHALL abandon the request; an imem_ack arriving after reset with imem_req=0 SHALL be ignored.
REQ-030 The first request SHALL appear in the first cycle after reset is released with pc=0, at imem_addr=0.

Structure
REQ-031 The state encodings (IDLE=0, BUSY=1, DRAIN=2) and the DEPTH default SHALL reside in a shared package, inst_prefetch_pkg.
REQ-032 The queue SHALL be a sub-module, prefetch_fifo (DEPTH x 32, with push, pop, flush, count, head data); the FSM and address registers SHALL stay in inst_prefetch.

Verification
REQ-033 The bench SHALL cover: reset, then pc=0, zero-wait memory, inst_ready=1 -> imem_addr 0,4,8,...; inst_valid from cycle 2; inst equals memory[pc] every cycle.
REQ-034 The bench SHALL cover: inst_ready=0, zero-wait memory -> exactly 4 requests (0x0-0xC); imem_req low with count=4; one pop -> a single request at 0x10.
REQ-035 The bench SHALL cover: a 3-wait-state memory with pc redirected to 0x100 during BUSY at 0x8 -> req held at 0x8 until ack, data dropped, next request 0x100, and the first inst_valid with inst=memory[0x100].
REQ-036 The bench SHALL cover: a redirect to 0x40 in the same cycle as an ack for 0xC -> the 0xC data is not queued, count=0, next imem_addr=0x40.
REQ-037 The bench SHALL cover: pc=0xFFFFFFF8 with a streaming memory -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, with correct data at each wrap.
REQ-038 The bench SHALL cover: reset asserted during DRAIN with a pending ack -> after the edge imem_req=0, inst_valid=0, and a late ack leaves count=0.
